wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage and a long-latency multi-cycle unit (divider / delayed load return). The pipeline gets priority; multi-cycle results are buffered in a small FIFO and drained into idle write slots. A starvation counter periodically stalls pipeline writeback to guarantee forward progress. The block sits between the writeback mux output and the register file write port.

## Interface

- XLEN, 32, datapath width
- REG_AW, 5, destination register index width
- DEPTH, 2, multi-cycle result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose arbitration before a forced drain (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_wb_valid  in  1  pipeline writeback request; sampled only when wb_stall=0
- pipe_wb_rd  in  REG_AW  pipeline destination register
- pipe_wb_data  in  XLEN  pipeline writeback data (selected ALU/memory/PC value)
- wb_stall  out  1  registered; pipeline must hold its writeback (no loss) while high
- mc_valid  in  1  multi-cycle result valid
- mc_ready  out  1  FIFO can accept; transfer when mc_valid && mc_ready
- mc_rd  in  REG_AW  multi-cycle destination register
- mc_data  in  XLEN  multi-cycle result
- rf_we  out  1  registered register-file write enable
- rf_rd  out  REG_AW  registered write address
- rf_wdata  out  XLEN  registered write data

One clock; reset is asynchronous and active-low.

## Operation

- FIFO: DEPTH entries of {rd, data}, head/tail pointers wrap modulo DEPTH, count 0..DEPTH.
- mc_ready = rst_n && (count < DEPTH); based on current count only — a pop in the same cycle does not open a slot when full.
- Grant each cycle (combinational select, registered output):
  - wb_stall=0 and pipe_wb_valid=1: grant pipeline.
  - else FIFO non-empty: grant FIFO head, pop.
  - else: no write.
- Granted write with rd==0: consumed (pop if FIFO) but rf_we=0 next cycle; rf_rd/rf_wdata still load.
- No write: rf_we=0, rf_rd/rf_wdata hold.
- Push and pop in the same cycle allowed when count<DEPTH; count unchanged.
- FSM states NORMAL, DRAIN:
  - NORMAL: starve_cnt increments when FIFO non-empty and pipeline granted; clears on any FIFO pop or when FIFO empty. When starve_cnt reaches STARVE_LIMIT, next state DRAIN, wb_stall=1 next cycle.
  - DRAIN (wb_stall=1): FIFO head granted and popped (FIFO guaranteed non-empty); next state NORMAL, wb_stall=0, starve_cnt=0. Exactly one cycle per drain.
- WAW ordering between pipeline and FIFO is guaranteed by the issue scoreboard; this block does not check it.

## Timing

- Reset (async, rst_n low): rf_we=0, rf_rd=0, rf_wdata=0, wb_stall=0, FIFO empty, starve_cnt=0, state NORMAL, mc_ready=0. After release mc_ready=1.
- Pipeline request sampled at edge k -> rf_we/rf_rd/rf_wdata valid in cycle k+1 (latency 1).
- mc transfer at edge k -> earliest rf write cycle k+2 (FIFO latency + output register).
- wb_stall asserted the cycle after starve_cnt hits STARVE_LIMIT; deasserted the following cycle.
- Reset mid-operation discards FIFO contents and any pending stall.

## Test plan

- Reset: hold rst_n=0 with mc_valid=1 -> rf_we=0, wb_stall=0, mc_ready=0; release -> mc_ready=1 next sample, no writes.
- Pipeline only: pipe_wb_valid=1, rd=7, data=0xDEADBEEF at edge k -> rf_we=1, rf_rd=7, rf_wdata=0xDEADBEEF in cycle k+1; rd=0 -> rf_we=0.
- Idle-slot drain: push mc rd=3 data=0x11 with pipe idle -> rf write rd=3, 0x11 two cycles later; FIFO empty afterward.
- Full FIFO: push DEPTH=2 entries while pipeline writes every cycle -> mc_ready=0, third mc_valid held; pop frees slot, mc_ready=1 the following cycle; no entry lost or reordered.
- Starvation: one FIFO entry, pipe_wb_valid=1 continuously, STARVE_LIMIT=4 -> 4 pipeline writes, wb_stall=1 for one cycle, FIFO entry written next, pipeline resumes with held request unchanged.
- Async reset asserted with 2 FIFO entries and wb_stall=1 -> all outputs at reset values immediately; after release no stale FIFO writes appear.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multi-cycle
// results queue in a small FIFO and drain into idle slots; a starvation counter
// forces a one-cycle pipeline stall so a waiting FIFO head always makes progress.
module wb_port_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wb_valid,
  input  logic [REG_AW-1:0] pipe_wb_rd,
  input  logic [XLEN-1:0]   pipe_wb_data,
  output logic              wb_stall,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [REG_AW-1:0] mc_rd,
  input  logic [XLEN-1:0]   mc_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    ST_NORMAL,
    ST_DRAIN
  } state_t;

  logic [REG_AW-1:0] r_fifo_rd   [DEPTH];
  logic [XLEN-1:0]   r_fifo_data [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  state_t            r_state;
  logic [SW-1:0]     r_starve_cnt;
  logic              r_wb_stall;

  logic              r_rf_we;
  logic [REG_AW-1:0] r_rf_rd;
  logic [XLEN-1:0]   r_rf_wdata;

  logic              w_fifo_nonempty;
  logic              w_mc_ready;
  logic              w_push;
  logic              w_grant_pipe;
  logic              w_pop;
  logic [SW-1:0]     w_starve_next;
  logic [REG_AW-1:0] w_head_rd;
  logic [XLEN-1:0]   w_head_data;

  assign w_fifo_nonempty = (r_count != '0);
  // Readiness looks at the current occupancy only; a same-cycle pop never frees a full FIFO.
  assign w_mc_ready      = rst_n && (r_count < CW'(DEPTH));
  assign w_push          = mc_valid && w_mc_ready;
  assign w_grant_pipe    = !r_wb_stall && pipe_wb_valid;
  assign w_pop           = !w_grant_pipe && w_fifo_nonempty;
  assign w_starve_next   = r_starve_cnt + SW'(1);
  assign w_head_rd       = r_fifo_rd[r_head];
  assign w_head_data     = r_fifo_data[r_head];

  assign mc_ready = w_mc_ready;
  assign wb_stall = r_wb_stall;
  assign rf_we    = r_rf_we;
  assign rf_rd    = r_rf_rd;
  assign rf_wdata = r_rf_wdata;

  // FIFO storage: contents need no reset, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_tail]   <= mc_rd;
      r_fifo_data[r_tail] <= mc_data;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation FSM: counts pipeline wins over a waiting FIFO head, then stalls for one drain cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_NORMAL;
      r_starve_cnt <= '0;
      r_wb_stall   <= 1'b0;
    end else begin
      case (r_state)
        ST_NORMAL: begin
          if (!w_fifo_nonempty || w_pop) begin
            r_starve_cnt <= '0;
          end else if (w_grant_pipe) begin
            r_starve_cnt <= w_starve_next;
            if (w_starve_next == SW'(STARVE_LIMIT)) begin
              r_state    <= ST_DRAIN;
              r_wb_stall <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          r_state      <= ST_NORMAL;
          r_starve_cnt <= '0;
          r_wb_stall   <= 1'b0;
        end
        default: begin
          r_state      <= ST_NORMAL;
          r_starve_cnt <= '0;
          r_wb_stall   <= 1'b0;
        end
      endcase
    end
  end

  // Registered write port: writes to x0 are consumed but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
    end else if (w_grant_pipe) begin
      r_rf_we    <= (pipe_wb_rd != '0);
      r_rf_rd    <= pipe_wb_rd;
      r_rf_wdata <= pipe_wb_data;
    end else if (w_pop) begin
      r_rf_we    <= (w_head_rd != '0);
      r_rf_rd    <= w_head_rd;
      r_rf_wdata <= w_head_data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic, all
// checked against a queue-based transaction model of the write-port rules.
module tb_wb_port_arbiter;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned REG_AW       = 5;
  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic              clk;
  logic              rst_n;
  logic              pipe_wb_valid;
  logic [REG_AW-1:0] pipe_wb_rd;
  logic [XLEN-1:0]   pipe_wb_data;
  logic              wb_stall;
  logic              mc_valid;
  logic              mc_ready;
  logic [REG_AW-1:0] mc_rd;
  logic [XLEN-1:0]   mc_data;
  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wdata;

  wb_port_arbiter #(
    .XLEN(XLEN),
    .REG_AW(REG_AW),
    .DEPTH(DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pipe_wb_valid(pipe_wb_valid),
    .pipe_wb_rd(pipe_wb_rd),
    .pipe_wb_data(pipe_wb_data),
    .wb_stall(wb_stall),
    .mc_valid(mc_valid),
    .mc_ready(mc_ready),
    .mc_rd(mc_rd),
    .mc_data(mc_data),
    .rf_we(rf_we),
    .rf_rd(rf_rd),
    .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   d;
  } ent_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model state: buffered results, pending stall, wait-streak of the buffered head.
  ent_t              q[$];
  ent_t              pend[$];
  bit                m_stall;
  int                m_starve;
  bit                e_we;
  logic [REG_AW-1:0] e_rd;
  logic [XLEN-1:0]   e_wd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_stall  = 1'b0;
    m_starve = 0;
    e_we     = 1'b0;
    e_rd     = '0;
    e_wd     = '0;
  endtask

  // What the next rising edge does, given the inputs currently driven.
  task automatic model_edge();
    bit   gp;
    bit   pop;
    bit   push;
    ent_t h;
    gp   = !m_stall && pipe_wb_valid;
    pop  = !gp && (q.size() > 0);
    push = mc_valid && (q.size() < DEPTH);
    if (gp) begin
      e_we = (pipe_wb_rd != 0);
      e_rd = pipe_wb_rd;
      e_wd = pipe_wb_data;
    end else if (pop) begin
      h    = q[0];
      e_we = (h.rd != 0);
      e_rd = h.rd;
      e_wd = h.d;
    end else begin
      e_we = 1'b0;
    end
    if (m_stall) begin
      m_stall  = 1'b0;
      m_starve = 0;
    end else if (q.size() == 0 || pop) begin
      m_starve = 0;
    end else begin
      m_starve++;
      if (m_starve == STARVE_LIMIT) m_stall = 1'b1;
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(ent_t'{rd: mc_rd, d: mc_data});
  endtask

  task automatic check_outputs();
    chk("rf_we",    64'(rf_we),    64'(e_we));
    chk("rf_rd",    64'(rf_rd),    64'(e_rd));
    chk("rf_wdata", 64'(rf_wdata), 64'(e_wd));
    chk("wb_stall", 64'(wb_stall), 64'(m_stall));
    chk("mc_ready", 64'(mc_ready), 64'(rst_n && (q.size() < DEPTH)));
  endtask

  // One clock: pipeline request held while stalled, mc offer held until accepted.
  task automatic cyc(input bit pv, input logic [REG_AW-1:0] prd, input logic [XLEN-1:0] pd);
    bit take;
    if (!m_stall) begin
      pipe_wb_valid = pv;
      pipe_wb_rd    = prd;
      pipe_wb_data  = pd;
    end
    mc_valid = (pend.size() > 0);
    if (mc_valid) begin
      mc_rd   = pend[0].rd;
      mc_data = pend[0].d;
    end else begin
      mc_rd   = REG_AW'($urandom);
      mc_data = $urandom;
    end
    take = mc_valid && (q.size() < DEPTH);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    if (take) void'(pend.pop_front());
  endtask

  initial begin
    rst_n         = 1'b0;
    pipe_wb_valid = 1'b0;
    pipe_wb_rd    = '0;
    pipe_wb_data  = '0;
    mc_valid      = 1'b1;
    mc_rd         = 5'd9;
    mc_data       = 32'hCAFE;
    model_reset();

    // Reset held with mc_valid high
    repeat (3) @(negedge clk);
    chk("rst_we",    64'(rf_we),    64'd0);
    chk("rst_stall", 64'(wb_stall), 64'd0);
    chk("rst_ready", 64'(mc_ready), 64'd0);
    chk("rst_rd",    64'(rf_rd),    64'd0);
    rst_n = 1'b1;
    cyc(0, '0, '0);
    chk("rel_ready", 64'(mc_ready), 64'd1);
    chk("rel_we",    64'(rf_we),    64'd0);

    // Pipeline only
    cyc(1, 5'd7, 32'hDEADBEEF);
    chk("pipe_we", 64'(rf_we),    64'd1);
    chk("pipe_rd", 64'(rf_rd),    64'd7);
    chk("pipe_wd", 64'(rf_wdata), 64'hDEADBEEF);
    cyc(1, 5'd0, 32'h1234);
    chk("pipe_x0_we", 64'(rf_we), 64'd0);

    // Idle-slot drain: written two cycles after the transfer
    pend.push_back(ent_t'{rd: 5'd3, d: 32'h11});
    cyc(0, '0, '0);
    chk("drain_early_we", 64'(rf_we), 64'd0);
    cyc(0, '0, '0);
    chk("drain_we", 64'(rf_we),    64'd1);
    chk("drain_rd", 64'(rf_rd),    64'd3);
    chk("drain_wd", 64'(rf_wdata), 64'h11);
    cyc(0, '0, '0);
    chk("drain_empty_we", 64'(rf_we), 64'd0);

    // Full FIFO while the pipeline writes every cycle
    pend.push_back(ent_t'{rd: 5'd4, d: 32'hA4});
    pend.push_back(ent_t'{rd: 5'd5, d: 32'hA5});
    pend.push_back(ent_t'{rd: 5'd6, d: 32'hA6});
    cyc(1, 5'd10, 32'h100);
    cyc(1, 5'd11, 32'h101);
    chk("full_ready", 64'(mc_ready), 64'd0);
    for (int i = 0; i < 8; i++) cyc(1, REG_AW'(12 + i), 32'h200 + 32'(i));
    repeat (4) cyc(0, '0, '0);

    // Starvation with one buffered entry and a continuous pipeline request
    pend.push_back(ent_t'{rd: 5'd9, d: 32'hBEEF});
    for (int i = 0; i < 5; i++) cyc(1, 5'd20, 32'h5555);
    chk("starve_stall", 64'(wb_stall), 64'd1);
    cyc(1, 5'd20, 32'h5555);
    chk("starve_fifo_rd", 64'(rf_rd),    64'd9);
    chk("starve_fifo_wd", 64'(rf_wdata), 64'hBEEF);
    chk("starve_unstall", 64'(wb_stall), 64'd0);
    cyc(1, 5'd20, 32'h5555);
    chk("starve_resume_rd", 64'(rf_rd),    64'd20);
    chk("starve_resume_we", 64'(rf_we),    64'd1);
    repeat (2) cyc(0, '0, '0);

    // Async reset with two buffered entries and a pending stall
    pend.push_back(ent_t'{rd: 5'd1, d: 32'hD1});
    pend.push_back(ent_t'{rd: 5'd2, d: 32'hD2});
    for (int i = 0; i < 5; i++) cyc(1, 5'd8, 32'h88);
    chk("pre_rst_stall", 64'(wb_stall), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_we",    64'(rf_we),    64'd0);
    chk("arst_rd",    64'(rf_rd),    64'd0);
    chk("arst_wd",    64'(rf_wdata), 64'd0);
    chk("arst_stall", 64'(wb_stall), 64'd0);
    chk("arst_ready", 64'(mc_ready), 64'd0);
    model_reset();
    pend.delete();
    pipe_wb_valid = 1'b0;
    mc_valid      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cyc(0, '0, '0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (pend.size() < 2 && $urandom_range(0, 99) < 35)
        pend.push_back(ent_t'{rd: REG_AW'($urandom_range(0, 7)), d: $urandom});
      cyc($urandom_range(0, 99) < 70, REG_AW'($urandom_range(0, 7)), $urandom);
    end
    pend.delete();
    repeat (4) cyc(0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
